// File: rtl/pr_bus_dma.sv
// pr_bus_dma: Pr-bus initiator that copies a block of 32-bit words from one
// bridge-mapped range to another, one read + one write per word, and raises
// a sticky level interrupt when the block is done.
module pr_bus_dma #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  input  logic             irq_ack,
  input  logic [31:0]      PrRD,
  output logic [31:0]      PrAddr,
  output logic [31:0]      PrWD,
  output logic             PrWE,
  output logic             busy,
  output logic             done,
  output logic             irq
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t           state_q;
  logic [29:0]      src_ptr_q;
  logic [29:0]      dst_ptr_q;
  logic [LEN_W-1:0] count_q;
  logic [31:0]      buf_q;
  logic             irq_q;
  logic             irq_d;

  // Byte-offset bits of the addresses are intentionally ignored.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{src[1:0], dst[1:0]};

  // Transfer sequencer: latch the request, then alternate READ/WRITE per word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      count_q   <= '0;
      buf_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            src_ptr_q <= src[31:2];
            dst_ptr_q <= dst[31:2];
            count_q   <= len;
            state_q   <= (len != '0) ? READ : FINISH;
          end
        end
        READ: begin
          buf_q     <= PrRD;
          src_ptr_q <= src_ptr_q + 30'd1;
          state_q   <= WRITE;
        end
        WRITE: begin
          dst_ptr_q <= dst_ptr_q + 30'd1;
          count_q   <= count_q - LEN_W'(1);
          state_q   <= (count_q == LEN_W'(1)) ? FINISH : READ;
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky interrupt: setting on the FINISH exit edge takes priority over ack.
  always_comb begin
    irq_d = irq_q;
    if (state_q == FINISH) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end
  end

  // Interrupt register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  // Bus outputs decoded from the current state and the pointer registers.
  always_comb begin
    PrAddr = '0;
    case (state_q)
      READ:    PrAddr = {src_ptr_q, 2'b00};
      WRITE:   PrAddr = {dst_ptr_q, 2'b00};
      default: PrAddr = '0;
    endcase
  end

  assign PrWD = buf_q;
  assign PrWE = (state_q == WRITE);
  assign busy = (state_q == READ) || (state_q == WRITE);
  assign done = (state_q == FINISH);
  assign irq  = irq_q;

endmodule

// File: tb/tb_pr_bus_dma.sv
// Directed testbench for pr_bus_dma with a simple bus model that returns
// 0xA5A5_0000 + address on every read.
module tb_pr_bus_dma;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] src;
  logic [31:0] dst;
  logic [7:0]  len;
  logic        irq_ack;
  logic [31:0] PrRD;
  logic [31:0] PrAddr;
  logic [31:0] PrWD;
  logic        PrWE;
  logic        busy;
  logic        done;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  pr_bus_dma #(.LEN_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .src     (src),
    .dst     (dst),
    .len     (len),
    .irq_ack (irq_ack),
    .PrRD    (PrRD),
    .PrAddr  (PrAddr),
    .PrWD    (PrWD),
    .PrWE    (PrWE),
    .busy    (busy),
    .done    (done),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus model: combinational read data derived from the address.
  always_comb PrRD = 32'hA5A5_0000 + PrAddr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Check the full observable output set in one call.
  task automatic chk_all(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                         input logic we, input logic bsy, input logic dn, input logic ir);
    chk({tag, ".PrAddr"}, PrAddr, addr);
    chk({tag, ".PrWD"},   PrWD,   wd);
    chk({tag, ".PrWE"},   {31'd0, PrWE}, {31'd0, we});
    chk({tag, ".busy"},   {31'd0, busy}, {31'd0, bsy});
    chk({tag, ".done"},   {31'd0, done}, {31'd0, dn});
    chk({tag, ".irq"},    {31'd0, irq},  {31'd0, ir});
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [7:0] l);
    @(negedge clk);
    src   = s;
    dst   = d;
    len   = l;
    start = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    src     = '0;
    dst     = '0;
    len     = '0;
    irq_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk_all("rst", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Idle for 5 cycles after reset.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_all("idle", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // len=2 copy 0x7F00 -> 0x7F10.
    launch(32'h7F00, 32'h7F10, 8'd2);
    @(negedge clk); start = 1'b0;
    chk_all("t1.c1", 32'h7F00, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_all("t1.c2", 32'h7F10, 32'hA5A5_7F00, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_all("t1.c3", 32'h7F04, 32'hA5A5_7F00, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_all("t1.c4", 32'h7F14, 32'hA5A5_7F04, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_all("t1.c5", 32'h0, 32'hA5A5_7F04, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_all("t1.c6", 32'h0, 32'hA5A5_7F04, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1.irq_hold", {31'd0, irq}, 32'd1);
    irq_ack = 1'b1;
    @(negedge clk);
    chk("t1.ack", {31'd0, irq}, 32'd0);
    irq_ack = 1'b0;

    // len=0: straight to FINISH, no bus cycles.
    launch(32'h1234, 32'h5678, 8'd0);
    @(negedge clk); start = 1'b0;
    chk_all("z.c1", 32'h0, 32'hA5A5_7F04, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_all("z.c2", 32'h0, 32'hA5A5_7F04, 1'b0, 1'b0, 1'b0, 1'b1);
    irq_ack = 1'b1;
    @(negedge clk);
    chk("z.ack", {31'd0, irq}, 32'd0);
    irq_ack = 1'b0;

    // Ack on the same edge that FINISH sets irq: set wins; next ack clears.
    launch(32'h0, 32'h0, 8'd0);
    @(negedge clk); start = 1'b0;
    chk("sa.done", {31'd0, done}, 32'd1);
    irq_ack = 1'b1;
    @(negedge clk);
    chk("sa.setwins", {31'd0, irq}, 32'd1);
    @(negedge clk);
    chk("sa.cleared", {31'd0, irq}, 32'd0);
    irq_ack = 1'b0;

    // start re-pulsed mid-transfer with other addresses is ignored.
    launch(32'h0100, 32'h0200, 8'd2);
    @(negedge clk);
    chk_all("ig.c1", 32'h0100, 32'hA5A5_7F04, 1'b0, 1'b1, 1'b0, 1'b0);
    src = 32'h0900; dst = 32'h0A00; len = 8'd5;
    @(negedge clk); start = 1'b0;
    chk_all("ig.c2", 32'h0200, 32'hA5A5_0100, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_all("ig.c3", 32'h0104, 32'hA5A5_0100, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_all("ig.c4", 32'h0204, 32'hA5A5_0104, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_all("ig.c5", 32'h0, 32'hA5A5_0104, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_all("ig.c6", 32'h0, 32'hA5A5_0104, 1'b0, 1'b0, 1'b0, 1'b1);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;

    // Word pointer wraps modulo 2^30; address bits [1:0] ignored.
    launch(32'hFFFF_FFFF, 32'h0000_0003, 8'd2);
    @(negedge clk); start = 1'b0;
    chk("wr.rd0", PrAddr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wr.wa0", PrAddr, 32'h0000_0000);
    chk("wr.wd0", PrWD, 32'hA5A4_FFFC);
    @(negedge clk);
    chk("wr.rd1", PrAddr, 32'h0000_0000);
    @(negedge clk);
    chk("wr.wa1", PrAddr, 32'h0000_0004);
    chk("wr.wd1", PrWD, 32'hA5A5_0000);
    @(negedge clk);
    chk("wr.done", {31'd0, done}, 32'd1);
    irq_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("wr.ack", {31'd0, irq}, 32'd0);
    irq_ack = 1'b0;

    // Asynchronous reset during the WRITE of word 2 of a len=4 transfer.
    launch(32'h0040, 32'h0080, 8'd4);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk_all("ar.w2", 32'h0084, 32'hA5A5_0044, 1'b1, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk_all("ar.async", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_all("ar.after", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
